// File: rtl/tc_input_arbiter.sv
// tc_input_arbiter: shares the TinyComp input port between NREQ producers.
// A one-word holding register feeds the core and is refilled by a
// round-robin arbiter, so a word seen with InRdy high stays put until the
// core consumes it. One word per Ph0 cycle sustained.
// Optional build macro: TC_INPUT_ARB_TAG_EN -- replaces bits [31:24] of the
// held word with the granted requester index.
module tc_input_arbiter #(
    parameter int NREQ = 4,
    parameter int SRCW = 2
) (
    input  logic                 Ph0,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      ReqValid,
    input  logic [32*NREQ-1:0]   ReqData,
    output logic [NREQ-1:0]      ReqReady,
    input  logic                 InStrobe,
    output logic [31:0]          InData,
    output logic                 InRdy,
    output logic [SRCW-1:0]      InSrc,
    output logic                 Underflow
);

    if (SRCW != $clog2(NREQ)) begin : g_srcw_check
        $error("SRCW must equal clog2(NREQ)");
    end

    logic            hold_valid;
    logic [31:0]     hold_data;
    logic [SRCW-1:0] hold_src;
    logic [SRCW-1:0] last;
    logic            underflow_q;

    logic            consume;
    logic            open;
    logic            grant_found;
    logic [SRCW-1:0] grant_idx;
    logic [31:0]     grant_word;
    logic [31:0]     load_word;

    assign consume = InStrobe & hold_valid;
    assign open    = ~hold_valid | consume;

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        logic [SRCW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = SRCW'((int'(last) + k) % NREQ);
            if (!grant_found && ReqValid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_word = ReqData[32*grant_idx +: 32];

`ifdef TC_INPUT_ARB_TAG_EN
    // Top byte carries the source index so software can demultiplex.
    assign load_word = {8'(grant_idx), grant_word[23:0]};
`else
    assign load_word = grant_word;
`endif

    // Handshake back to the winning producer; never completes during Reset.
    always_comb begin
        ReqReady = '0;
        if (!Reset && open && grant_found) begin
            ReqReady[grant_idx] = 1'b1;
        end
    end

    // Holding register, round-robin pointer and sticky underflow flag.
    always_ff @(posedge Ph0) begin
        if (Reset) begin
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            hold_src    <= '0;
            last        <= SRCW'(NREQ - 1);
            underflow_q <= 1'b0;
        end else begin
            if (open && grant_found) begin
                hold_valid <= 1'b1;
                hold_data  <= load_word;
                hold_src   <= grant_idx;
                last       <= grant_idx;
            end else if (consume) begin
                hold_valid <= 1'b0;
            end
            if (InStrobe && !hold_valid) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign InRdy     = hold_valid;
    assign InData    = hold_valid ? hold_data : 32'h0;
    assign InSrc     = hold_src;
    assign Underflow = underflow_q;

endmodule
